// File: rtl/team_06_audio_route_ctrl.sv
// Audio route controller: picks the speaker or transmit path from the control FSM
// outputs and ramps gain down and back up around every route or effect change.
module team_06_audio_route_ctrl #(
    parameter int          FADE_STEP = 4,
    parameter logic [7:0]  MID       = 8'd128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_stb,
    input  logic [1:0] fsm_state,
    input  logic       vol_en,
    input  logic       eff_en,
    input  logic [2:0] current_effect,
    input  logic       mute_tog,
    input  logic [7:0] mic_aud,
    input  logic [7:0] eff_aud,
    input  logic [7:0] spk_aud,
    output logic [7:0] spk_out,
    output logic       spk_valid,
    output logic [7:0] tx_out,
    output logic       tx_valid,
    output logic [1:0] route,
    output logic [2:0] eff_sel,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_PLAY     = 2'b00,
        ST_FADE_OUT = 2'b01,
        ST_FADE_IN  = 2'b10
    } state_t;

    localparam logic [1:0] RT_SILENT = 2'b00;
    localparam logic [1:0] RT_SPK    = 2'b01;
    localparam logic [1:0] RT_TX     = 2'b10;
    localparam logic [5:0] STEP6     = 6'(FADE_STEP);
    localparam logic [4:0] GAIN_MAX  = 5'd16;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_gain;
    logic [4:0] w_gain_nxt;
    logic [4:0] w_gain_up;
    logic [4:0] w_gain_dn;
    logic [5:0] w_gain_sum;
    logic [1:0] r_route;
    logic       r_eff_en_q;
    logic [2:0] r_eff_sel;
    logic       r_busy;
    logic [7:0] r_spk_out;
    logic [7:0] r_tx_out;
    logic       r_spk_valid;
    logic       r_tx_valid;
    logic [1:0] w_tgt_route;
    logic       w_mismatch;
    logic       w_load;

    // Scale an offset-binary sample by gain/16 around the MID level; never leaves 0..255.
    function automatic logic [7:0] f_scale(input logic [7:0] x, input logic [4:0] g);
        logic signed [8:0]  s;
        logic signed [14:0] p;
        logic signed [14:0] q;
        s = $signed({1'b0, x}) - 9'sd128;
        p = 15'(s) * 15'($signed({1'b0, g}));
        q = (p >>> 4) + 15'sd128;
        return q[7:0];
    endfunction

    // Target route and mismatch against the applied configuration.
    always_comb begin
        w_tgt_route = RT_SILENT;
        if (fsm_state == 2'b01) begin
            w_tgt_route = RT_TX;
        end else if (vol_en && !mute_tog) begin
            w_tgt_route = RT_SPK;
        end else begin
            w_tgt_route = RT_SILENT;
        end
        // Effect fields only matter when the transmit path is the destination.
        w_mismatch = (w_tgt_route != r_route) ||
                     ((w_tgt_route == RT_TX) &&
                      ((eff_en != r_eff_en_q) || (current_effect != r_eff_sel)));
    end

    // Saturating gain steps.
    always_comb begin
        w_gain_sum = {1'b0, r_gain} + STEP6;
        if (w_gain_sum >= 6'd16) begin
            w_gain_up = GAIN_MAX;
        end else begin
            w_gain_up = w_gain_sum[4:0];
        end
        if ({1'b0, r_gain} > STEP6) begin
            w_gain_dn = r_gain - STEP6[4:0];
        end else begin
            w_gain_dn = 5'd0;
        end
    end

    // Fade sequencer next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_gain_nxt  = r_gain;
        w_load      = 1'b0;
        if (sample_stb) begin
            case (r_state)
                ST_PLAY: begin
                    if (w_mismatch && (r_gain == 5'd0)) begin
                        w_load      = 1'b1;
                        w_state_nxt = (w_tgt_route == RT_SILENT) ? ST_PLAY : ST_FADE_IN;
                    end else if (w_mismatch) begin
                        w_state_nxt = ST_FADE_OUT;
                    end else begin
                        w_state_nxt = ST_PLAY;
                    end
                end
                ST_FADE_OUT: begin
                    w_gain_nxt = w_gain_dn;
                    if (w_gain_dn == 5'd0) begin
                        w_load      = 1'b1;
                        w_state_nxt = (w_tgt_route == RT_SILENT) ? ST_PLAY : ST_FADE_IN;
                    end else begin
                        w_state_nxt = ST_FADE_OUT;
                    end
                end
                ST_FADE_IN: begin
                    // A new target during fade-in reverses from the current gain.
                    if (w_mismatch) begin
                        w_state_nxt = ST_FADE_OUT;
                    end else begin
                        w_gain_nxt  = w_gain_up;
                        w_state_nxt = (w_gain_up == GAIN_MAX) ? ST_PLAY : ST_FADE_IN;
                    end
                end
                default: begin
                    w_state_nxt = ST_PLAY;
                    w_gain_nxt  = 5'd0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State, applied configuration and sample outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_PLAY;
            r_gain      <= 5'd0;
            r_route     <= RT_SILENT;
            r_eff_en_q  <= 1'b0;
            r_eff_sel   <= 3'd0;
            r_busy      <= 1'b0;
            r_spk_out   <= MID;
            r_tx_out    <= MID;
            r_spk_valid <= 1'b0;
            r_tx_valid  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gain      <= w_gain_nxt;
            r_busy      <= (w_state_nxt != ST_PLAY);
            r_spk_valid <= sample_stb;
            r_tx_valid  <= sample_stb;
            if (sample_stb) begin
                case (r_route)
                    RT_SPK: begin
                        r_spk_out <= f_scale(spk_aud, r_gain);
                        r_tx_out  <= MID;
                    end
                    RT_TX: begin
                        r_spk_out <= MID;
                        r_tx_out  <= f_scale(r_eff_en_q ? eff_aud : mic_aud, r_gain);
                    end
                    default: begin
                        r_spk_out <= MID;
                        r_tx_out  <= MID;
                    end
                endcase
                // Off the transmit path the effect selection follows its inputs freely.
                if (w_load) begin
                    r_route    <= w_tgt_route;
                    r_eff_en_q <= eff_en;
                    r_eff_sel  <= current_effect;
                end else if (r_route != RT_TX) begin
                    r_eff_en_q <= eff_en;
                    r_eff_sel  <= current_effect;
                end else begin
                    r_eff_en_q <= r_eff_en_q;
                    r_eff_sel  <= r_eff_sel;
                end
            end else begin
                r_spk_out <= r_spk_out;
                r_tx_out  <= r_tx_out;
            end
        end
    end

    assign spk_out   = r_spk_out;
    assign tx_out    = r_tx_out;
    assign spk_valid = r_spk_valid;
    assign tx_valid  = r_tx_valid;
    assign route     = r_route;
    assign eff_sel   = r_eff_sel;
    assign busy      = r_busy;

endmodule
